// File: rtl/alu_control_mdu.sv
// ALU control decode for the single-cycle RV32 core, plus an iterative RV32M
// multiply/divide sequencer that stalls the pipeline until its result is ready.
//
// state | meaning
// IDLE  | waiting for an MDU instruction
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | sign fix-up, result load, stall released
module alu_control_mdu #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [2:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [6:0]        opCode,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              is_mdu,
  output logic              stall,
  output logic              mdu_busy,
  output logic              result_valid,
  output logic [XLEN-1:0]   mdu_result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] C_SRL  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] C_XOR  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] C_SRA  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] C_MDU  = CTRL_W'(15);

  localparam logic [6:0]      OP_R   = 7'b0110011;
  localparam logic [XLEN-1:0] SMIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES   = {XLEN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd_m;
  logic [XLEN-1:0] dividend_raw;
  logic [2:0]      op_f3;
  logic            neg_main;
  logic            neg_rem;
  logic            div_zero;
  logic            div_ovf;
  logic [CW-1:0]   cnt;

  // ---------------- combinational decode ----------------
  always_comb begin
    ALUControl = C_ADD;
    is_mdu     = 1'b0;
    case (ALUOp)
      3'b000: ALUControl = C_ADD;
      3'b001: ALUControl = C_SUB;
      3'b011: ALUControl = C_SRL;
      3'b010: begin
        if (opCode == OP_R && funct7 == 7'h01) begin
          ALUControl = C_MDU;
          is_mdu     = 1'b1;
        end else begin
          case (funct3)
            3'b000: ALUControl = (opCode == OP_R && funct7 == 7'h20) ? C_SUB : C_ADD;
            3'b001: ALUControl = C_SLL;
            3'b010: ALUControl = C_SLT;
            3'b011: ALUControl = C_SLTU;
            3'b100: ALUControl = C_XOR;
            3'b101: ALUControl = (funct7 == 7'h20) ? C_SRA : C_SRL;
            3'b110: ALUControl = C_OR;
            default: ALUControl = C_AND;
          endcase
        end
      end
      default: ALUControl = C_ADD;
    endcase
  end

  assign stall    = in_valid & is_mdu & (state != S_DONE);
  assign mdu_busy = (state != S_IDLE);

  // ---------------- operand preparation at accept ----------------
  logic            a_signed, b_signed, a_neg, b_neg, acc_div, acc_zero, acc_ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg    = a_signed & operand_a[XLEN-1];
    b_neg    = b_signed & operand_b[XLEN-1];
    a_mag    = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_mag    = b_neg ? (~operand_b + 1'b1) : operand_b;
    acc_div  = funct3[2];
    acc_zero = acc_div && (operand_b == '0);
    acc_ovf  = acc_div && !funct3[0] && (operand_a == SMIN) && (operand_b == ONES);
  end

  // ---------------- datapath steps ----------------
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_m} : {(XLEN+1){1'b0}});
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_m};
  end

  // Sign fix-up and half select, evaluated while in DONE.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  always_comb begin
    prod_s = neg_main ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    quot_s = neg_main ? (~acc_lo + 1'b1) : acc_lo;
    rem_s  = neg_rem  ? (~acc_hi + 1'b1) : acc_hi;
    case (op_f3)
      3'd0:         final_res = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:         final_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:   final_res = div_zero ? ONES : (div_ovf ? SMIN : quot_s);
      default:      final_res = div_zero ? dividend_raw : (div_ovf ? '0 : rem_s);
    endcase
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      acc_hi       <= '0;
      acc_lo       <= '0;
      opnd_m       <= '0;
      dividend_raw <= '0;
      op_f3        <= '0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      div_ovf      <= 1'b0;
      cnt          <= '0;
      result_valid <= 1'b0;
      mdu_result   <= '0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_valid && is_mdu) begin
              acc_hi       <= '0;
              acc_lo       <= a_mag;
              opnd_m       <= b_mag;
              dividend_raw <= operand_a;
              op_f3        <= funct3;
              neg_main     <= a_neg ^ b_neg;
              neg_rem      <= a_neg;
              div_zero     <= acc_zero;
              div_ovf      <= acc_ovf;
              cnt          <= CW'(XLEN-1);
              if (acc_zero || acc_ovf) state <= S_DONE;
              else if (acc_div)        state <= S_DIV;
              else                     state <= S_MUL;
            end
          end
          S_MUL: begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            if (cnt == '0) state <= S_DONE;
            else           cnt   <= cnt - 1'b1;
          end
          S_DIV: begin
            if (!div_diff[XLEN]) begin
              acc_hi <= div_diff[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
            if (cnt == '0) state <= S_DONE;
            else           cnt   <= cnt - 1'b1;
          end
          default: begin
            mdu_result   <= final_res;
            result_valid <= 1'b1;
            state        <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MDU results and latency,
// divide special cases, flush and reset mid-operation.
module tb_alu_control_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, flush;
  logic [2:0]      ALUOp, funct3;
  logic [6:0]      funct7, opCode;
  logic [XLEN-1:0] operand_a, operand_b;
  logic [3:0]      ALUControl;
  logic            is_mdu, stall, mdu_busy, result_valid;
  logic [XLEN-1:0] mdu_result;

  int checks = 0;
  int errors = 0;

  alu_control_mdu #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .opCode(opCode),
    .operand_a(operand_a), .operand_b(operand_b),
    .ALUControl(ALUControl), .is_mdu(is_mdu), .stall(stall),
    .mdu_busy(mdu_busy), .result_valid(result_valid), .mdu_result(mdu_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [6:0] op, input logic [3:0] exp_ctrl, input logic exp_mdu,
                     input string tag);
    in_valid = 1'b0;
    ALUOp = aop; funct3 = f3; funct7 = f7; opCode = op;
    #1;
    check({tag, "_ctrl"}, ALUControl, exp_ctrl);
    check({tag, "_mdu"}, is_mdu, exp_mdu);
  endtask

  // Presents an MDU op, counts stalled cycles, checks the DONE cycle and the result.
  task automatic run_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string tag);
    int n;
    ALUOp = 3'b010; opCode = 7'b0110011; funct7 = 7'h01; funct3 = f3;
    operand_a = a; operand_b = b; in_valid = 1'b1;
    #1;
    check({tag, "_stall_start"}, stall, 1'b1);
    n = 0;
    while (stall && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_stall_cycles"}, n, exp_lat);
    check({tag, "_busy_done"}, mdu_busy, 1'b1);
    check({tag, "_rv_early"}, result_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    check({tag, "_rv"}, result_valid, 1'b1);
    check({tag, "_result"}, mdu_result, exp_res);
    check({tag, "_busy_after"}, mdu_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    ALUOp = 3'b000; funct3 = 3'b000; funct7 = 7'h00; opCode = 7'b0110011;
    operand_a = '0; operand_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_busy", mdu_busy, 1'b0);
    check("rst_rv", result_valid, 1'b0);
    check("rst_result", mdu_result, 32'h0);

    dec(3'b010, 3'b000, 7'h20, 7'b0110011, 4'd6,  1'b0, "sub_r");
    dec(3'b010, 3'b000, 7'h20, 7'b0010011, 4'd2,  1'b0, "addi_f7");
    dec(3'b010, 3'b000, 7'h00, 7'b0110011, 4'd2,  1'b0, "add_r");
    dec(3'b010, 3'b101, 7'h20, 7'b0110011, 4'd10, 1'b0, "sra");
    dec(3'b010, 3'b101, 7'h00, 7'b0110011, 4'd3,  1'b0, "srl");
    dec(3'b010, 3'b001, 7'h00, 7'b0110011, 4'd7,  1'b0, "sll");
    dec(3'b010, 3'b010, 7'h00, 7'b0110011, 4'd4,  1'b0, "slt");
    dec(3'b010, 3'b011, 7'h00, 7'b0110011, 4'd8,  1'b0, "sltu");
    dec(3'b010, 3'b100, 7'h00, 7'b0110011, 4'd9,  1'b0, "xor");
    dec(3'b010, 3'b110, 7'h00, 7'b0110011, 4'd1,  1'b0, "or");
    dec(3'b010, 3'b111, 7'h00, 7'b0110011, 4'd0,  1'b0, "and");
    dec(3'b010, 3'b100, 7'h01, 7'b0110011, 4'd15, 1'b1, "mdu");
    dec(3'b000, 3'b000, 7'h01, 7'b0110011, 4'd2,  1'b0, "aluop0");
    dec(3'b001, 3'b000, 7'h00, 7'b1100011, 4'd6,  1'b0, "aluop1");
    dec(3'b011, 3'b000, 7'h00, 7'b0110011, 4'd3,  1'b0, "aluop3");
    dec(3'b100, 3'b000, 7'h20, 7'b0110011, 4'd2,  1'b0, "aluop4");

    // Non-MDU instruction presented: no stall, sequencer untouched.
    ALUOp = 3'b010; funct3 = 3'b000; funct7 = 7'h20; opCode = 7'b0110011; in_valid = 1'b1;
    #1;
    check("nonmdu_stall", stall, 1'b0);
    tick();
    check("nonmdu_busy", mdu_busy, 1'b0);
    in_valid = 1'b0;

    run_mdu(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_mdu(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_mdu(3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 33, "mulh");
    run_mdu(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_mdu(3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div");
    run_mdu(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem");
    run_mdu(3'd5, 32'd100,      32'd7,        32'd14,        33, "divu");
    run_mdu(3'd7, 32'd100,      32'd7,        32'd2,         33, "remu");
    run_mdu(3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  "div0");
    run_mdu(3'd6, 32'd5,        32'd0,        32'd5,         1,  "rem0");
    run_mdu(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divovf");
    run_mdu(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1, "removf");

    // No restart after DONE with the instruction dropped.
    tick();
    check("idle_rv", result_valid, 1'b0);
    check("idle_busy", mdu_busy, 1'b0);

    // Flush mid-MUL at cycle 10.
    ALUOp = 3'b010; opCode = 7'b0110011; funct7 = 7'h01; funct3 = 3'd0;
    operand_a = 32'd9; operand_b = 32'd9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("flush_busy_pre", mdu_busy, 1'b1);
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    check("flush_busy", mdu_busy, 1'b0);
    check("flush_rv", result_valid, 1'b0);
    check("flush_result", mdu_result, 32'h0);
    begin
      int seen = 0;
      for (int i = 0; i < XLEN + 4; i++) begin
        tick();
        if (result_valid) seen++;
      end
      check("flush_no_rv", seen, 0);
    end

    // Back-to-back ops, then reset mid-DIV.
    run_mdu(3'd5, 32'd100, 32'd7, 32'd14, 33, "b2b_1");
    run_mdu(3'd0, 32'd6,   32'd7, 32'd42, 33, "b2b_2");
    ALUOp = 3'b010; opCode = 7'b0110011; funct7 = 7'h01; funct3 = 3'd4;
    operand_a = 32'd50; operand_b = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rst_mid_busy_pre", mdu_busy, 1'b1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", mdu_busy, 1'b0);
    check("rst_mid_rv", result_valid, 1'b0);
    check("rst_mid_result", mdu_result, 32'h0);
    check("rst_mid_stall", stall, 1'b0);
    run_mdu(3'd4, 32'd50, 32'd3, 32'd16, 33, "post_rst_div");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Second-generation ALU control for the single-cycle RV32 core, parametrised in datapath and control-code width.
- Decodes ALUOp/funct3/funct7/opCode into a widened ALU control code for single-cycle ops, covering the full RV32I register/immediate set.
- Adds an iterative multiply/divide sequencer for the RV32M ops (R-type, funct7=0x01). It stalls the pipeline until the result is ready.
- Sits between the main control unit and the ALU. Its result mux feeds writeback.

Parameters:
- XLEN, 32, operand/result width (>=8, even)
- CTRL_W, 4, ALU control code width (>=4)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  an instruction is presented this cycle
- flush  in  1  synchronous abort of any MDU operation in flight
- ALUOp  in  3  class from main control
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- opCode  in  7  instr[6:0]
- operand_a  in  XLEN  rs1 value
- operand_b  in  XLEN  rs2 value
- ALUControl  out  CTRL_W  combinational ALU op code
- is_mdu  out  1  decoded op is RV32M (combinational)
- stall  out  1  hold PC/pipeline this cycle
- mdu_busy  out  1  sequencer not IDLE
- result_valid  out  1  one-cycle pulse: mdu_result is valid
- mdu_result  out  XLEN  MDU result, held until next completion

Behaviour:
- ALUControl codes (zero-extended to CTRL_W):
  - AND=0, OR=1, ADD=2, SRL=3, SLT=4, SUB=6, SLL=7, SLTU=8, XOR=9, SRA=10, MDU=15
- Decode by ALUOp:
  - 000: ADD
  - 001: SUB
  - 011: SRL
  - 010: by funct3:
    - 000: SUB if opCode=0110011 and funct7=0x20, else ADD
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRA if funct7=0x20, else SRL
    - 110: OR
    - 111: AND
  - 010 override: opCode=0110011 and funct7=0x01 gives MDU and is_mdu=1.
  - Any other ALUOp: ADD. Decode is fully combinational, with no latches.
- The rst input does not affect the decode.
- MDU funct3 mapping:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- Sequencer states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL/DIV when in_valid & is_mdu. This latches operands, funct3 and magnitudes: absolute value for signed operands, per op.
  - MUL: radix-2 shift-add over a 2*XLEN accumulator, one bit per cycle, XLEN cycles, then DONE.
  - DIV: restoring divide, one quotient bit per cycle, XLEN cycles, then DONE.
  - Divide special cases are detected in IDLE and go straight to DONE:
    - divisor 0: quotient all ones, remainder = dividend
    - signed MIN / -1: quotient MIN, remainder 0
  - DONE: apply sign fix-up (negate product/quotient/remainder as RISC-V requires) and select the low or high half. Load mdu_result, pulse result_valid, then return to IDLE.
- Latency: accepted at edge k gives result_valid high in the cycle after edge k+XLEN+1. The special-case divide path takes one cycle in DONE.
- stall = in_valid & is_mdu & (state != DONE).
  - Stall drops in the DONE cycle, so the pipeline advances and captures mdu_result.
  - The instruction still presented in DONE must not restart the sequencer.
- Back-to-back MDU ops: the next op starts from IDLE the cycle after DONE.
- mdu_busy = (state != IDLE).
- flush or rst has priority over everything else:
  - next state is IDLE; no result_valid is produced.
  - rst also clears mdu_result to 0 and all internal registers to 0.
- Reset values: stall=0 (given in_valid=0), mdu_busy=0, result_valid=0, mdu_result=0.
- Non-MDU instructions never touch the sequencer, and stall stays 0 for them.

Test Plan:
- ALUOp=010, opCode=0110011, funct3=000, funct7=0x20 -> ALUControl=6. With funct3=101, funct7=0x20 -> 10. With ALUOp=100 -> 2.
- MUL, a=7, b=-3 -> stall high for XLEN+1 cycles, result_valid at k+XLEN+1, mdu_result=0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV a=-7, b=2 -> mdu_result=0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14.
- DIV by 0, a=5 -> mdu_result=0xFFFFFFFF after 1-cycle DONE path. REM a=5, b=0 -> 5. DIV 0x80000000 / -1 -> 0x80000000.
- flush asserted mid-MUL (cycle 10) -> next cycle state IDLE, mdu_busy=0, no result_valid, mdu_result unchanged.
- Two back-to-back MDU ops, then rst mid-DIV -> first result captured correctly. After reset all outputs are 0 and a new op runs with full latency.
